adam_pause_seq: RTL
===================

ADAM_PAUSE_SEQ -- requirements
Module: adam_pause_seq

Interface
REQ-001 Parameter NO_SLVS, default 4: number of downstream pause slaves sequenced, legal 1..32.
REQ-002 Parameter GAP, default 0: idle cycles inserted after each downstream ack before the next slave is handled, legal 0..255.
REQ-003 Parameter TIMEOUT, default 1024: cycles a single downstream handshake may take before err is raised, legal 2..65535.
REQ-004 seq.clk  input  1  single clock; all state changes on rising edge.
REQ-005 seq.rst  input  1  asynchronous, active-high reset.
REQ-006 pause.req  input  1  upstream pause request (1 = pause, 0 = run).
REQ-007 pause.ack  output  1  upstream acknowledge; equals pause.req once the whole group has settled.
REQ-008 slv_pause[i].req  output  1 each, NO_SLVS entries  downstream pause request to slave i.
REQ-009 slv_pause[i].ack  input  1 each, NO_SLVS entries  downstream acknowledge from slave i.
REQ-010 err  output  1  sticky: some downstream handshake exceeded TIMEOUT cycles.

Function
REQ-011 Handshake rule, both sides: a master changes req only while req == ack; a slave changes ack only toward req.
REQ-012 States: PAUSED, RESUMING, GAP_WAIT, RUNNING, PAUSING; index idx, width $clog2(NO_SLVS) (min 1).
REQ-013 PAUSED: all slv req = 1, pause.ack = 1; on pause.req == 0 -> RESUMING, idx = 0, slv[0].req = 0 on the same edge.
REQ-014 RESUMING: slaves released in ascending order 0..NO_SLVS-1; slv[idx].req = 0 held until slv[idx].ack == 0.
REQ-015 On ack match with idx < NO_SLVS-1: GAP == 0 -> idx+1 and next req toggled on the same edge; GAP > 0 -> GAP_WAIT for exactly GAP cycles, then next req toggled.
REQ-016 On ack match of last slave: -> RUNNING, pause.ack = 0 on that edge (1-cycle latency from last ack).
REQ-017 RUNNING: all slv req = 0, pause.ack = 0; on pause.req == 1 -> PAUSING, idx = NO_SLVS-1, slv[NO_SLVS-1].req = 1.
REQ-018 PAUSING: slaves paused in descending order NO_SLVS-1..0, same gap rules as REQ-015; after slave 0 acks -> PAUSED, pause.ack = 1.
REQ-019 GAP_WAIT returns to the direction it came from (resume or pause); direction held in a 1-bit register.
REQ-020 pause.req changes while pause.ack != pause.req are protocol violations; the sequence in progress completes unaffected.
REQ-021 Timeout counter clears on every downstream req change; counts while slv[idx].ack != slv[idx].req; reaching TIMEOUT sets err; sequence keeps waiting (no skip).
REQ-022 err clears only on reset.
REQ-023 NO_SLVS == 1: no GAP_WAIT ever entered; latency upstream req -> slv req = 1 cycle, slv ack -> upstream ack = 1 cycle.
REQ-024 A slave whose ack already equals the new req is accepted on the next edge (minimum 1 cycle per slave).
REQ-025 All outputs registered; no combinational path from any input to any output.

Reset
REQ-026 During seq.rst: state = PAUSED, idx = 0, all slv req = 1, pause.ack = 1, err = 0, counters = 0.
REQ-027 Reset asserted mid-RESUMING/PAUSING forces reset values immediately, regardless of downstream ack.
REQ-028 After reset release: remain PAUSED until pause.req == 0.

Structure
REQ-029 Shared package adam_pause_seq_pkg holds the state enum and direction encoding.
REQ-030 One sub-module adam_pause_seq_cnt: loadable down-counter with done flag, instantiated twice (gap, timeout).

Verification
REQ-031 NO_SLVS=3, GAP=0, slaves ack 1 cycle after req: drop pause.req -> slv req fall order 0,1,2, pause.ack falls 1 cycle after slv[2].ack.
REQ-032 Same, raise pause.req from RUNNING -> slv req rise order 2,1,0, pause.ack rises 1 cycle after slv[0].ack.
REQ-033 NO_SLVS=3, GAP=2 -> exactly 2 idle cycles between each slv ack and the next slv req change, both directions.
REQ-034 TIMEOUT=16, slave 1 withholds ack 40 cycles -> err = 1 at cycle 16, sequence completes after ack, err stays 1.
REQ-035 seq.rst asserted during RESUMING with slv[1] pending -> all slv req = 1, pause.ack = 1, err = 0 asynchronously.
REQ-036 NO_SLVS=1, slave acks in the same cycle -> full resume/pause round trip of 2 cycles per direction.

Source files
------------

// File: rtl/adam_pause_seq_pkg.sv
// adam_pause_seq_pkg: shared state and direction encodings for the pause sequencer
package adam_pause_seq_pkg;
  typedef enum logic [2:0] {PAUSED, RESUMING, GAP_WAIT, RUNNING, PAUSING} state_t;
  typedef enum logic {DIR_RESUME = 1'b0, DIR_PAUSE = 1'b1} dir_t;
endpackage

// File: rtl/adam_pause_seq_cnt.sv
// adam_pause_seq_cnt: loadable down-counter that saturates at zero and flags done
module adam_pause_seq_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - W'(1);
  assign done = cnt == '0;
endmodule

// File: rtl/adam_pause_seq.sv
// adam_pause_seq: releases downstream slaves in ascending order and pauses them in descending order
module adam_pause_seq
  import adam_pause_seq_pkg::*;
#(
  parameter int NO_SLVS = 4,
  parameter int GAP     = 0,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pause_req,
  output logic               pause_ack,
  output logic [NO_SLVS-1:0] slv_req,
  input  logic [NO_SLVS-1:0] slv_ack,
  output logic               err
);
  localparam int IW = NO_SLVS > 1 ? $clog2(NO_SLVS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NO_SLVS - 1);
  state_t state, state_d;
  dir_t dir, dir_d;
  logic [IW-1:0] idx, idx_d, nxt;
  logic [NO_SLVS-1:0] slv_req_d;
  logic pause_ack_d, match, busy, last, kick, gap_load, gap_done, to_done;
  assign match = slv_ack[idx] == slv_req[idx];
  assign busy  = state == RESUMING || state == PAUSING;
  assign last  = dir == DIR_RESUME ? idx == LAST : idx == IW'(0);
  assign nxt   = dir == DIR_RESUME ? idx + IW'(1) : idx - IW'(1);
  always_comb begin
    state_d     = state;
    dir_d       = dir;
    idx_d       = idx;
    slv_req_d   = slv_req;
    pause_ack_d = pause_ack;
    kick        = 1'b0;
    gap_load    = 1'b0;
    case (state)
      PAUSED: if (!pause_req) begin
        state_d      = RESUMING;
        dir_d        = DIR_RESUME;
        idx_d        = '0;
        slv_req_d[0] = 1'b0;
        kick         = 1'b1;
      end
      RUNNING: if (pause_req) begin
        state_d              = PAUSING;
        dir_d                = DIR_PAUSE;
        idx_d                = LAST;
        slv_req_d[NO_SLVS-1] = 1'b1;
        kick                 = 1'b1;
      end
      RESUMING, PAUSING: if (match) begin
        if (last) begin
          state_d     = dir == DIR_RESUME ? RUNNING : PAUSED;
          pause_ack_d = dir == DIR_PAUSE;
        end else if (GAP == 0) begin
          idx_d          = nxt;
          slv_req_d[nxt] = dir == DIR_PAUSE;
          kick           = 1'b1;
        end else begin
          state_d  = GAP_WAIT;
          gap_load = 1'b1;
        end
      end
      GAP_WAIT: if (gap_done) begin
        state_d        = dir == DIR_RESUME ? RESUMING : PAUSING;
        idx_d          = nxt;
        slv_req_d[nxt] = dir == DIR_PAUSE;
        kick           = 1'b1;
      end
      default: state_d = PAUSED;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= PAUSED;
      dir       <= DIR_RESUME;
      idx       <= '0;
      slv_req   <= '1;
      pause_ack <= 1'b1;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      dir       <= dir_d;
      idx       <= idx_d;
      slv_req   <= slv_req_d;
      pause_ack <= pause_ack_d;
      err       <= err | (busy & ~match & to_done);
    end
  // Gap load of GAP-1 plus the exit edge yields exactly GAP cycles spent in GAP_WAIT
  adam_pause_seq_cnt #(.W(8)) u_gap (
    .clk(clk), .rst(rst), .load(gap_load), .en(state == GAP_WAIT),
    .load_val(8'(GAP > 0 ? GAP - 1 : 0)), .done(gap_done)
  );
  adam_pause_seq_cnt #(.W(16)) u_to (
    .clk(clk), .rst(rst), .load(kick), .en(busy & ~match),
    .load_val(16'(TIMEOUT - 1)), .done(to_done)
  );
endmodule
